// File: rtl/rr_arbiter_bin_idx.sv
// rtl/rr_arbiter_bin_idx.sv - round-robin arbiter producing a registered binary grant index
// Grant index feeds a binary-to-one-hot decoder; ptr_o exposes the rotating priority pointer.
module rr_arbiter_bin_idx #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  output logic             gnt_valid_o,
  input  logic             gnt_ready_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [IDX_W-1:0] ptr_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] hi_idx, lo_idx;
  logic             hi_found;
  logic             any_req;
  logic             handshake;

  assign any_req   = |req_i;
  assign handshake = (state_q == GRANT) && gnt_ready_i;

  // Wrap at N_REQ rather than 2^IDX_W so non-power-of-two sizes stay in range.
  assign next_ptr = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign pick_ptr = handshake ? next_ptr : ptr_q;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        lo_idx = IDX_W'(k);
        if (k >= int'(pick_ptr)) begin
          hi_idx   = IDX_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_idx_d = pick_idx;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready_i) begin
          ptr_d = next_ptr;
          if (any_req) begin
            gnt_idx_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_idx_o   = gnt_idx_q;
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_bin_idx.sv
// tb/tb_rr_arbiter_bin_idx.sv - bench for rr_arbiter_bin_idx at N_REQ=16 and N_REQ=5
module tb_rr_arbiter_bin_idx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req16;
  logic        rdy16;
  logic        v16;
  logic [3:0]  idx16, ptr16;
  logic [4:0]  req5;
  logic        rdy5;
  logic        v5;
  logic [2:0]  idx5, ptr5;

  int checks = 0;
  int errors = 0;
  int mv[2]   = '{0, 0};
  int midx[2] = '{0, 0};
  int mptr[2] = '{0, 0};

  always #5 clk = ~clk;

  rr_arbiter_bin_idx #(.N_REQ(16), .IDX_W(4)) u_dut16 (
    .clk(clk), .reset(reset), .req_i(req16), .gnt_valid_o(v16),
    .gnt_ready_i(rdy16), .gnt_idx_o(idx16), .ptr_o(ptr16)
  );

  rr_arbiter_bin_idx #(.N_REQ(5), .IDX_W(3)) u_dut5 (
    .clk(clk), .reset(reset), .req_i(req5), .gnt_valid_o(v5),
    .gnt_ready_i(rdy5), .gnt_idx_o(idx5), .ptr_o(ptr5)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First requester at or after ptr, walking the ring of n requesters.
  function automatic int pick_m(input int ptr, input logic [15:0] req, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = (ptr + i) % n;
      if (((req >> k) & 16'h1) != 16'h0) return k;
    end
    return 0;
  endfunction

  task automatic model_step(input int d, input logic [15:0] req, input logic rdy, input int n);
    if (reset) begin
      mv[d] = 0; midx[d] = 0; mptr[d] = 0;
    end else if (mv[d] == 0) begin
      if (req != 16'h0) begin
        midx[d] = pick_m(mptr[d], req, n);
        mv[d]   = 1;
      end
    end else if (rdy) begin
      mptr[d] = (midx[d] + 1) % n;
      if (req != 16'h0) midx[d] = pick_m(mptr[d], req, n);
      else mv[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, req16, rdy16, 16);
    model_step(1, {11'b0, req5}, rdy5, 5);
    @(negedge clk);
    check("m16_valid", int'(v16), mv[0]);
    check("m16_idx", int'(idx16), midx[0]);
    check("m16_ptr", int'(ptr16), mptr[0]);
    check("m5_valid", int'(v5), mv[1]);
    check("m5_idx", int'(idx5), midx[1]);
    check("m5_ptr", int'(ptr5), mptr[1]);
    check("m5_idx_range", int'(idx5 < 3'd5), 1);
    check("m5_ptr_range", int'(ptr5 < 3'd5), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_valid", int'(v16), 0);
    check("rst_idx", int'(idx16), 0);
    check("rst_ptr", int'(ptr16), 0);
    reset = 1'b0;
  endtask

  initial begin
    int sparse_idx[4];
    int sparse_ptr[4];
    sparse_idx = '{0, 5, 15, 0};
    sparse_ptr = '{1, 6, 0, 1};
    reset = 1'b1; req16 = 16'h0; rdy16 = 1'b0; req5 = 5'h0; rdy5 = 1'b0;

    // All requests, always ready: strict rotation on both sizes.
    req16 = 16'hFFFF; rdy16 = 1'b1; req5 = 5'b11111; rdy5 = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tick();
      check("rot16_valid", int'(v16), 1);
      check("rot16_idx", int'(idx16), i % 16);
      if (i < 6) check("rot5_idx", int'(idx5), i % 5);
    end

    req16 = 16'h8021; rdy16 = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) check("sparse_idx", int'(idx16), sparse_idx[i]);
      if (i > 0) check("sparse_ptr", int'(ptr16), sparse_ptr[i-1]);
    end

    req16 = 16'h0020; rdy16 = 1'b0;
    do_reset();
    tick();
    check("stall_first", int'(idx16), 5);
    req16 = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_idx", int'(idx16), 5);
      check("stall_valid", int'(v16), 1);
    end
    rdy16 = 1'b1;
    tick();
    check("stall_next_idx", int'(idx16), 0);
    check("stall_next_ptr", int'(ptr16), 6);

    req16 = 16'h0008; rdy16 = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sole_idx", int'(idx16), 3);
      if (i > 0) check("sole_ptr", int'(ptr16), 4);
    end
    req16 = 16'h0;
    tick();
    check("sole_drop_valid", int'(v16), 0);
    check("sole_drop_idx", int'(idx16), 3);

    req16 = 16'h0080; rdy16 = 1'b0;
    do_reset();
    tick();
    check("midrst_pending", int'(idx16), 7);
    rdy16 = 1'b1; reset = 1'b1;
    tick();
    check("midrst_valid", int'(v16), 0);
    check("midrst_idx", int'(idx16), 0);
    check("midrst_ptr", int'(ptr16), 0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      req16 = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
      rdy16 = ($urandom_range(0, 3) != 0);
      req5  = ($urandom_range(0, 7) == 0) ? 5'h0 : 5'($urandom);
      rdy5  = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
